booth_inverse_divider: RTL and testbench
========================================

Name: booth_inverse_divider

Overview:
- Sequential signed divider: the inverse operation of the team's shift-add Booth multiplier.
- Takes a 2*BIT_LEN-bit two's-complement dividend, the same width as the multiplier product, and a BIT_LEN-bit signed divisor.
- Returns a BIT_LEN-bit quotient and remainder using restoring division on magnitudes, one bit per clock, followed by sign fix-up.
- Sits beside the multiplier on the arithmetic datapath and uses a start/busy/done handshake.

Parameters:
BIT_LEN, 4, operand width; dividend is 2*BIT_LEN bits, divisor/quotient/remainder are BIT_LEN bits.

Ports:
clk  input  1  clock, all state changes on rising edge
rstn  input  1  synchronous, active-high reset (sampled on rising clk)
start  input  1  request a division; accepted only when busy=0
IN1  input  2*BIT_LEN  signed dividend, sampled on the accepting edge
IN2  input  BIT_LEN  signed divisor, sampled on the accepting edge
QUO  output  BIT_LEN  signed quotient, truncated toward zero
REM  output  BIT_LEN  signed remainder, sign of dividend (or zero)
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle
dz  output  1  divide-by-zero flag for the last result
ovf  output  1  quotient overflow flag for the last result

Behaviour:
- Reset (rstn=1 at an edge):
  - state=IDLE.
  - QUO=0, REM=0, busy=0, done=0, dz=0, ovf=0.
  - Iteration counter and internal registers cleared.
  - Applies from any state; an in-flight division is discarded with no done pulse.
- State IDLE (busy=0):
  - If start=1, latch sign(IN1), sign(IN2), |IN1| (2*BIT_LEN bits), |IN2| (BIT_LEN+1 bits to hold |-2^(BIT_LEN-1)|).
  - Clear the partial remainder; set cnt=2*BIT_LEN.
  - Next state: FIXUP if IN2==0, otherwise ITER.
- State ITER (busy=1), one restoring step per cycle:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial subtract |divisor| from the partial remainder. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - cnt decrements; after the step taken with cnt==1, go to FIXUP.
  - Exactly 2*BIT_LEN ITER cycles.
- State FIXUP (busy=1), one cycle; registers outputs, sets done=1, returns to IDLE:
  - Divisor zero: QUO=0, REM=0, dz=1, ovf=0.
  - Otherwise: quotient sign = sign(IN1) XOR sign(IN2); remainder sign = sign(IN1). Negate magnitudes where needed.
  - ovf=1 if the quotient magnitude exceeds 2^(BIT_LEN-1)-1 (positive result) or 2^(BIT_LEN-1) (negative result).
  - On overflow QUO = low BIT_LEN bits of the signed quotient; REM is still exact. dz=0.
- done: high for exactly the one cycle after the FIXUP edge, then low.
- Latency, counted in rising edges after the edge that accepts start:
  - Non-zero divisor: done and results visible after edge 2*BIT_LEN+1.
  - Zero divisor: visible after edge 1.
- QUO, REM, dz, ovf hold their value until the next FIXUP or reset.
- start while busy=1 is ignored (no queueing); inputs may change freely while busy.
- start in the same cycle done=1 (state IDLE) is accepted normally; done still drops next cycle.
- Dividend -2^(2*BIT_LEN-1) is handled: its magnitude fits in 2*BIT_LEN unsigned bits.
- A remainder of zero is reported as 0 regardless of dividend sign.

Test Plan:
All cases use BIT_LEN=4.
- Reset, then IN1=8'd45, IN2=4'd6, start 1 cycle -> busy=1 for 9 cycles; done after edge 9; QUO=4'd7, REM=4'd3, dz=0, ovf=0.
- IN1=-45 (8'hD3), IN2=6 -> QUO=4'b1001 (-7), REM=4'b1101 (-3). Then IN1=45, IN2=-8 (4'h8) -> QUO=-5 (4'hB), REM=4'd5.
- Overflow cases:
  - IN1=100, IN2=3 -> ovf=1, QUO=4'h1 (33 mod 16), REM=4'd1.
  - IN1=-128 (8'h80), IN2=-8 -> ovf=1, QUO=4'h0, REM=0.
  - IN1=-64, IN2=8'... use IN2=-8 with IN1=64 -> quotient -8 fits: ovf=0, QUO=4'h8.
- Divide by zero: IN2=0, any IN1 -> done after edge 1, dz=1, QUO=0, REM=0, ovf=0. The next valid divide clears dz.
- Handshake: pulse start again on cycle 3 of a busy division with different operands -> ignored, first result returned. Assert start in the done cycle -> second division accepted, its done arrives 9 edges later.
- Reset mid-ITER (cycle 4) -> next cycle busy=0, outputs zero, no done pulse. Round-trip: IN1=-56 (8'hC8), IN2=-8 -> QUO=4'd7, REM=0.

Source files
------------

// File: rtl/booth_inverse_divider.sv
// Sequential signed divider, the inverse of the shift-add Booth multiplier.
// Divides a 2*BIT_LEN-bit two's-complement dividend by a BIT_LEN-bit signed
// divisor using restoring division on magnitudes (one quotient bit per clock),
// then applies sign fix-up. Quotient truncates toward zero; remainder takes
// the dividend's sign.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rstn  - synchronous active-high reset
//   start - request a division, accepted only while busy=0
//   IN1   - signed dividend (2*BIT_LEN bits), sampled on the accepting edge
//   IN2   - signed divisor (BIT_LEN bits), sampled on the accepting edge
//   QUO   - signed quotient (low BIT_LEN bits on overflow)
//   REM   - signed remainder
//   busy  - high while a division is in progress
//   done  - one-cycle pulse when results update
//   dz    - divide-by-zero flag for the last result
//   ovf   - quotient overflow flag for the last result
`timescale 1ns/1ps

module booth_inverse_divider #(
  parameter int unsigned BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [2*BIT_LEN-1:0]   IN1,
  input  logic [BIT_LEN-1:0]     IN2,
  output logic [BIT_LEN-1:0]     QUO,
  output logic [BIT_LEN-1:0]     REM,
  output logic                   busy,
  output logic                   done,
  output logic                   dz,
  output logic                   ovf
);

  localparam int unsigned W2  = 2 * BIT_LEN;
  localparam int unsigned BW1 = BIT_LEN + 1;
  localparam int unsigned CW  = $clog2(W2 + 1);
  // Largest quotient magnitude representable for a negative / positive result
  localparam logic [W2-1:0] QNEG_MAX = W2'(1) << (BIT_LEN - 1);
  localparam logic [W2-1:0] QPOS_MAX = QNEG_MAX - W2'(1);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t              state;
  logic                sgn1;
  logic                sgn2;
  logic                dzp;
  logic [W2-1:0]       qm;     // dividend magnitude, shifts out as quotient shifts in
  logic [BW1-1:0]      dvs;    // divisor magnitude, one extra bit for |-2^(BIT_LEN-1)|
  logic [BIT_LEN-1:0]  prem;   // partial remainder, always < dvs
  logic [CW-1:0]       cnt;

  logic [W2-1:0]       in1_mag_c;
  logic [BW1-1:0]      in2_ext_c;
  logic [BW1-1:0]      in2_mag_c;
  logic [BW1-1:0]      shift_c;
  logic                fit_c;
  logic                qneg_c;
  logic [BIT_LEN-1:0]  qlo_c;
  logic [BIT_LEN-1:0]  quo_c;
  logic [BIT_LEN-1:0]  rem_c;
  logic                ovf_c;

  // Operand magnitudes; -2^(W2-1) maps to 2^(W2-1), which fits unsigned
  always_comb begin
    in1_mag_c = IN1[W2-1] ? W2'(-IN1) : IN1;
    in2_ext_c = {IN2[BIT_LEN-1], IN2};
    in2_mag_c = IN2[BIT_LEN-1] ? BW1'(-in2_ext_c) : in2_ext_c;
  end

  // One restoring step: shift in next dividend bit, trial-compare against divisor
  always_comb begin
    shift_c = {prem, qm[W2-1]};
    fit_c   = (shift_c >= dvs);
  end

  // Sign fix-up; only the low BIT_LEN quotient bits are reported on overflow
  always_comb begin
    qneg_c = sgn1 ^ sgn2;
    qlo_c  = qm[BIT_LEN-1:0];
    quo_c  = qneg_c ? BIT_LEN'(-qlo_c) : qlo_c;
    rem_c  = sgn1 ? BIT_LEN'(-prem) : prem;
    ovf_c  = qneg_c ? (qm > QNEG_MAX) : (qm > QPOS_MAX);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      sgn1  <= 1'b0;
      sgn2  <= 1'b0;
      dzp   <= 1'b0;
      qm    <= '0;
      dvs   <= '0;
      prem  <= '0;
      cnt   <= '0;
      QUO   <= '0;
      REM   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn1  <= IN1[W2-1];
            sgn2  <= IN2[BIT_LEN-1];
            qm    <= in1_mag_c;
            dvs   <= in2_mag_c;
            prem  <= '0;
            cnt   <= CW'(W2);
            dzp   <= (IN2 == '0);
            busy  <= 1'b1;
            state <= (IN2 == '0) ? FIXUP : ITER;
          end
        end
        ITER: begin
          prem <= fit_c ? BIT_LEN'(shift_c - dvs) : shift_c[BIT_LEN-1:0];
          qm   <= {qm[W2-2:0], fit_c};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (dzp) begin
            QUO <= '0;
            REM <= '0;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else begin
            QUO <= quo_c;
            REM <= rem_c;
            dz  <= 1'b0;
            ovf <= ovf_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_inverse_divider.sv
// Directed self-checking bench for booth_inverse_divider (BIT_LEN=4).
`timescale 1ns/1ps

module tb_booth_inverse_divider;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] IN1;
  logic [3:0] IN2;
  logic [3:0] QUO;
  logic [3:0] REM;
  logic       busy;
  logic       done;
  logic       dz;
  logic       ovf;

  int total  = 0;
  int passed = 0;

  booth_inverse_divider #(.BIT_LEN(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .IN1   (IN1),
    .IN2   (IN2),
    .QUO   (QUO),
    .REM   (REM),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive start for one cycle; returns at the negedge after the accepting edge
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    IN1 = a; IN2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic chk_res(input string tag, input logic [3:0] q, input logic [3:0] r,
                         input logic d, input logic o);
    chk({tag, ".quo"}, 8'(QUO), 8'(q));
    chk({tag, ".rem"}, 8'(REM), 8'(r));
    chk({tag, ".dz"},  8'(dz),  8'(d));
    chk({tag, ".ovf"}, 8'(ovf), 8'(o));
    chk({tag, ".busy_end"}, 8'(busy), 8'd0);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [3:0] b,
                     input logic [3:0] q, input logic [3:0] r, input logic d,
                     input logic o, input int lat);
    int n;
    launch(a, b);
    chk({tag, ".busy"}, 8'(busy), 8'd1);
    wait_done(n);
    chk({tag, ".lat"}, 8'(n), 8'(lat));
    chk_res(tag, q, r, d, o);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_drop"}, 8'(done), 8'd0);
  endtask

  initial begin
    int n;
    int dcount;
    rstn = 1'b1; start = 1'b0; IN1 = '0; IN2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk("rst.quo",  8'(QUO),  8'd0);
    chk("rst.rem",  8'(REM),  8'd0);
    chk("rst.busy", 8'(busy), 8'd0);
    chk("rst.done", 8'(done), 8'd0);
    chk("rst.dz",   8'(dz),   8'd0);
    chk("rst.ovf",  8'(ovf),  8'd0);

    run("p45d6",    8'd45,  4'd6, 4'd7, 4'd3, 1'b0, 1'b0, 9);
    run("n45d6",    8'hD3,  4'd6, 4'h9, 4'hD, 1'b0, 1'b0, 9);
    run("p45dm8",   8'd45,  4'h8, 4'hB, 4'd5, 1'b0, 1'b0, 9);
    run("ovf100d3", 8'd100, 4'd3, 4'h1, 4'd1, 1'b0, 1'b1, 9);
    run("ovfm128",  8'h80,  4'h8, 4'h0, 4'd0, 1'b0, 1'b1, 9);
    run("p64dm8",   8'd64,  4'h8, 4'h8, 4'd0, 1'b0, 1'b0, 9);
    run("dz",       8'd77,  4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1);
    run("rt",       8'hC8,  4'h8, 4'd7, 4'd0, 1'b0, 1'b0, 9);

    // start while busy is ignored
    launch(8'd45, 4'd6);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    IN1 = 8'd100; IN2 = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ign.lat", 8'(n + 3), 8'd9);
    chk_res("ign", 4'd7, 4'd3, 1'b0, 1'b0);

    // start in the done cycle is accepted
    IN1 = 8'hD3; IN2 = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.done_drop", 8'(done), 8'd0);
    chk("b2b.busy",      8'(busy), 8'd1);
    wait_done(n);
    chk("b2b.lat", 8'(n), 8'd9);
    chk_res("b2b", 4'h9, 4'hD, 1'b0, 1'b0);

    // reset mid-iteration discards the division
    launch(8'd45, 4'd6);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk("mrst.busy", 8'(busy), 8'd0);
    chk("mrst.quo",  8'(QUO),  8'd0);
    chk("mrst.rem",  8'(REM),  8'd0);
    chk("mrst.done", 8'(done), 8'd0);
    dcount = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mrst.no_done", 8'(dcount), 8'd0);

    run("rt2", 8'hC8, 4'h8, 4'd7, 4'd0, 1'b0, 1'b0, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
